// File: rtl/ntt_io_gearbox.sv
// Narrow-beat <-> wide-vector gearbox that sits between the NTT core and its stream interfaces.
// Build option NTT_IO_GEARBOX_OVF_DROP_EN: drop core vectors that arrive while the output buffer is busy.
module ntt_io_gearbox #(
   parameter int DATA_WIDTH_PER_INPUT = 28,
   parameter int INPUT_PER_CYCLE      = 32,
   parameter int LANES_PER_BEAT       = 1
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic                                                   in_valid,
   output logic                                                   in_ready,
   input  logic [LANES_PER_BEAT*DATA_WIDTH_PER_INPUT-1:0]         in_data,
   output logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]   core_in_data,
   output logic                                                   core_in_valid,
   input  logic                                                   core_in_ready,
   input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]   core_out_data,
   input  logic                                                   core_out_valid,
   output logic                                                   out_valid,
   input  logic                                                   out_ready,
   output logic [LANES_PER_BEAT*DATA_WIDTH_PER_INPUT-1:0]         out_data,
   output logic                                                   out_overflow
);

   localparam int W  = DATA_WIDTH_PER_INPUT;
   localparam int N  = INPUT_PER_CYCLE;
   localparam int L  = LANES_PER_BEAT;
   localparam int B  = N / L;
   localparam int CW = (B > 1) ? $clog2(B) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(B - 1);

   typedef logic [N-1:0][W-1:0] vec_t;

   vec_t            asm_q;
   vec_t            asm_next;
   vec_t            hold_q;
   logic            hold_valid;
   logic [CW-1:0]   in_cnt;
   logic            in_fire;
   logic            in_last;

   vec_t            obuf_q;
   logic            obuf_valid;
   logic [CW-1:0]   out_cnt;
   logic            out_fire;
   logic            out_last;
   logic            capture;
   logic            ovf_event;

   assign in_ready      = !rst && !((in_cnt == LAST_BEAT) && hold_valid && !core_in_ready);
   assign in_fire       = in_valid && in_ready;
   assign in_last       = in_fire && (in_cnt == LAST_BEAT);
   assign core_in_data  = hold_q;
   assign core_in_valid = hold_valid;

   // The completed vector includes the beat being accepted this cycle.
   always_comb begin
      asm_next = asm_q;
      for (int k = 0; k < B; k++) begin
         if (in_cnt == CW'(k)) begin
            for (int j = 0; j < L; j++) begin
               asm_next[k*L + j] = in_data[j*W +: W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_cnt     <= '0;
         asm_q      <= '0;
         hold_q     <= '0;
         hold_valid <= 1'b0;
      end else begin
         if (in_fire) begin
            asm_q  <= asm_next;
            in_cnt <= (in_cnt == LAST_BEAT) ? '0 : in_cnt + CW'(1);
         end
         if (in_last) begin
            hold_q     <= asm_next;
            hold_valid <= 1'b1;
         end else if (hold_valid && core_in_ready) begin
            hold_valid <= 1'b0;
         end
      end
   end

   assign out_valid = obuf_valid;
   assign out_fire  = obuf_valid && out_ready;
   assign out_last  = out_fire && (out_cnt == LAST_BEAT);
   assign capture   = core_out_valid && (!obuf_valid || out_last);
   assign ovf_event = core_out_valid && obuf_valid && !out_last;

   always_comb begin
      out_data = '0;
      for (int k = 0; k < B; k++) begin
         if (out_cnt == CW'(k)) begin
            for (int j = 0; j < L; j++) begin
               out_data[j*W +: W] = obuf_q[k*L + j];
            end
         end
      end
   end

`ifdef NTT_IO_GEARBOX_OVF_DROP_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         obuf_q     <= '0;
         obuf_valid <= 1'b0;
         out_cnt    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (out_fire) begin
            if (out_cnt == LAST_BEAT) begin
               out_cnt    <= '0;
               obuf_valid <= 1'b0;
            end else begin
               out_cnt <= out_cnt + CW'(1);
            end
         end
         // A capture in the last-beat cycle overrides the drain so frames run back to back.
         if (capture) begin
            obuf_q     <= core_out_data;
            obuf_valid <= 1'b1;
            out_cnt    <= '0;
         end else if (ovf_event) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign out_overflow = ovf_q;
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         obuf_q     <= '0;
         obuf_valid <= 1'b0;
         out_cnt    <= '0;
      end else begin
         if (out_fire) begin
            if (out_cnt == LAST_BEAT) begin
               out_cnt    <= '0;
               obuf_valid <= 1'b0;
            end else begin
               out_cnt <= out_cnt + CW'(1);
            end
         end
         // An overflowing vector replaces the frame in flight, truncating it.
         if (capture || ovf_event) begin
            obuf_q     <= core_out_data;
            obuf_valid <= 1'b1;
            out_cnt    <= '0;
         end
      end
   end

   assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_io_gearbox.sv
// Directed bench for ntt_io_gearbox with W=28, N=32, L=4 (8 beats per vector).
module tb_ntt_io_gearbox;

   localparam int W = 28;
   localparam int N = 32;
   localparam int L = 4;
   localparam int B = N / L;

   logic                     clk;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic [L*W-1:0]           in_data;
   logic [N-1:0][W-1:0]      core_in_data;
   logic                     core_in_valid;
   logic                     core_in_ready;
   logic [N-1:0][W-1:0]      core_out_data;
   logic                     core_out_valid;
   logic                     out_valid;
   logic                     out_ready;
   logic [L*W-1:0]           out_data;
   logic                     out_overflow;

   int checks;
   int failures;

   ntt_io_gearbox #(
      .DATA_WIDTH_PER_INPUT (W),
      .INPUT_PER_CYCLE      (N),
      .LANES_PER_BEAT       (L)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .core_in_data   (core_in_data),
      .core_in_valid  (core_in_valid),
      .core_in_ready  (core_in_ready),
      .core_out_data  (core_out_data),
      .core_out_valid (core_out_valid),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_overflow   (out_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [L*W-1:0] beatOf(input int base, input int k);
      logic [L*W-1:0] r;
      r = '0;
      for (int j = 0; j < L; j++) begin
         r[j*W +: W] = W'(base + k*L + j);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic iv, input logic [L*W-1:0] id, input logic cir,
                                input logic cov, input logic orr);
      in_valid       = iv;
      in_data        = id;
      core_in_ready  = cir;
      core_out_valid = cov;
      out_ready      = orr;
      #1;
   endtask

   task automatic loadCoreOut(input int base);
      for (int i = 0; i < N; i++) begin
         core_out_data[i] = W'(base + i);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkCoreIn(input string tag, input int base);
      for (int i = 0; i < N; i++) begin
         checkOutput(tag, 128'(core_in_data[i]), 128'(W'(base + i)));
      end
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rst            = 1'b1;
      in_valid       = 1'b0;
      in_data        = '0;
      core_in_ready  = 1'b0;
      core_out_valid = 1'b0;
      core_out_data  = '0;
      out_ready      = 1'b0;

      tick();
      tick();
      checkOutput("rst in_ready", 128'(in_ready), 128'(0));
      checkOutput("rst core_in_valid", 128'(core_in_valid), 128'(0));
      checkOutput("rst out_valid", 128'(out_valid), 128'(0));
      checkOutput("rst out_overflow", 128'(out_overflow), 128'(0));
      checkOutput("rst core_in_data", 128'(core_in_data[0]), 128'(0));
      checkOutput("rst out_data", 128'(out_data), 128'(0));
      rst = 1'b0;
      #1;
      checkOutput("in_ready after rst", 128'(in_ready), 128'(1));

      $display("[TB] single vector assembly");
      for (int k = 0; k < B; k++) begin
         applyStimulus(1'b1, beatOf(0, k), 1'b1, 1'b0, 1'b0);
         checkOutput("asm in_ready", 128'(in_ready), 128'(1));
         checkOutput("asm core_in_valid early", 128'(core_in_valid), 128'(0));
         tick();
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("asm core_in_valid", 128'(core_in_valid), 128'(1));
      checkCoreIn("asm lane", 0);
      tick();
      checkOutput("asm consumed", 128'(core_in_valid), 128'(0));

      $display("[TB] input backpressure");
      for (int k = 0; k < 15; k++) begin
         applyStimulus(1'b1, (k < B) ? beatOf(100, k) : beatOf(200, k - B), 1'b0, 1'b0, 1'b0);
         checkOutput("bp in_ready", 128'(in_ready), 128'(1));
         tick();
      end
      applyStimulus(1'b1, beatOf(200, 7), 1'b0, 1'b0, 1'b0);
      checkOutput("bp stall in_ready", 128'(in_ready), 128'(0));
      checkOutput("bp hold valid", 128'(core_in_valid), 128'(1));
      checkOutput("bp hold lane0", 128'(core_in_data[0]), 128'(100));
      tick();
      checkOutput("bp stall in_ready 2", 128'(in_ready), 128'(0));
      checkOutput("bp hold lane31", 128'(core_in_data[31]), 128'(131));
      tick();
      applyStimulus(1'b1, beatOf(200, 7), 1'b1, 1'b0, 1'b0);
      checkOutput("bp release in_ready", 128'(in_ready), 128'(1));
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp second valid", 128'(core_in_valid), 128'(1));
      checkOutput("bp in_ready after wrap", 128'(in_ready), 128'(1));
      checkCoreIn("bp second lane", 200);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("bp second consumed", 128'(core_in_valid), 128'(0));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      $display("[TB] output serialisation");
      loadCoreOut(32'h1000);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      checkOutput("out idle", 128'(out_valid), 128'(0));
      tick();
      for (int k = 0; k < B; k++) begin
         if (k == B - 1) begin
            loadCoreOut(32'h2000);
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
            checkOutput("out beat7 lane3", 128'(out_data[3*W +: W]), 128'(32'h101F));
         end else begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
         end
         checkOutput("out valid", 128'(out_valid), 128'(1));
         checkOutput("out beat", 128'(out_data), 128'(beatOf(32'h1000, k)));
         tick();
      end
      for (int k = 0; k < B; k++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
         checkOutput("stall valid", 128'(out_valid), 128'(1));
         checkOutput("stall beat held", 128'(out_data), 128'(beatOf(32'h2000, k)));
         tick();
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
         checkOutput("stall beat go", 128'(out_data), 128'(beatOf(32'h2000, k)));
         tick();
      end
      checkOutput("out drained", 128'(out_valid), 128'(0));

      $display("[TB] output overflow");
      loadCoreOut(32'h3000);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         checkOutput("ovf pre beat", 128'(out_data), 128'(beatOf(32'h3000, k)));
         tick();
      end
      loadCoreOut(32'h4000);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      checkOutput("ovf beat3", 128'(out_data), 128'(beatOf(32'h3000, 3)));
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
`ifdef NTT_IO_GEARBOX_OVF_DROP_EN
      checkOutput("ovf flag", 128'(out_overflow), 128'(1));
      for (int k = 4; k < B; k++) begin
         checkOutput("ovf kept beat", 128'(out_data), 128'(beatOf(32'h3000, k)));
         tick();
      end
`else
      checkOutput("ovf flag", 128'(out_overflow), 128'(0));
      for (int k = 0; k < B; k++) begin
         checkOutput("ovf new beat", 128'(out_data), 128'(beatOf(32'h4000, k)));
         tick();
      end
`endif
      checkOutput("ovf drained", 128'(out_valid), 128'(0));

      $display("[TB] reset mid-frame");
      loadCoreOut(32'h5000);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, beatOf(500, k), 1'b0, (k == 0), 1'b0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("pre-rst out_valid", 128'(out_valid), 128'(1));
      rst = 1'b1;
      #1;
      checkOutput("mid rst in_ready", 128'(in_ready), 128'(0));
      tick();
      rst = 1'b0;
      #1;
      checkOutput("post rst in_ready", 128'(in_ready), 128'(1));
      checkOutput("post rst out_valid", 128'(out_valid), 128'(0));
      checkOutput("post rst overflow", 128'(out_overflow), 128'(0));
      checkOutput("post rst core_in_valid", 128'(core_in_valid), 128'(0));
      for (int k = 0; k < B; k++) begin
         applyStimulus(1'b1, beatOf(600, k), 1'b0, 1'b0, 1'b0);
         checkOutput("fresh no early vector", 128'(core_in_valid), 128'(0));
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("fresh valid", 128'(core_in_valid), 128'(1));
      checkCoreIn("fresh lane", 600);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("fresh consumed", 128'(core_in_valid), 128'(0));
      tick();
      checkOutput("fresh only one vector", 128'(core_in_valid), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ntt_io_gearbox.md
# ntt_io_gearbox

Parametrised width-conversion front/back end for the NTT core. Accepts a narrow beat stream of polynomial coefficients with valid/ready handshake and assembles full INPUT_PER_CYCLE-lane vectors for the core's wide input. Captures the core's wide output vectors and re-serialises them into a narrow beat stream with valid/ready handshake. Replaces the fixed one-lane-per-cycle IO wrapper: configurable lanes per beat, backpressure on both sides, and double buffering so the core is never starved between vectors.

## Interface
- DATA_WIDTH_PER_INPUT, 28, bits per coefficient lane (W)
- INPUT_PER_CYCLE, 32, lanes per wide core vector (N)
- LANES_PER_BEAT, 1, lanes per narrow beat (L); N % L == 0, N/L = B beats per vector, B ≥ 2
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  narrow input beat valid
- in_ready  out  1  narrow input beat accepted when in_valid && in_ready
- in_data  in  L*W  lane j of the beat in bits [j*W +: W]
- core_in_data  out  N x W array  assembled vector to core
- core_in_valid  out  1  core_in_data valid, held until core_in_ready
- core_in_ready  in  1  core accepts vector
- core_out_data  in  N x W array  result vector from core
- core_out_valid  in  1  single-cycle strobe, no backpressure to core
- out_valid  out  1  narrow output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  L*W  lane j of current beat in bits [j*W +: W]
- out_overflow  out  1  sticky: core vector arrived while output buffer busy

## Operation
- Input side: assembly register (N lanes) + hold register (N lanes, hold_valid). Beat counter in_cnt 0..B-1; accepted beat k writes lanes k*L..k*L+L-1; in_cnt wraps B-1 → 0.
- On accepting beat B-1: assembled vector copied to hold register, hold_valid set. core_in_data = hold register; core_in_valid = hold_valid; hold_valid clears on core_in_valid && core_in_ready (same-cycle reload from assembly wins, stays set).
- in_ready = !rst && !(in_cnt == B-1 && hold_valid && !core_in_ready).
- Output side: output buffer (N lanes), obuf_valid, beat counter out_cnt 0..B-1. out_valid = obuf_valid; out_data = lanes out_cnt*L..out_cnt*L+L-1. Each out_valid && out_ready advances out_cnt; on beat B-1, out_cnt → 0 and obuf_valid clears.
- core_out_valid captured into buffer if !obuf_valid, or if last beat is handshaken that same cycle (back-to-back, no bubble); out_cnt → 0.
- core_out_valid while buffer busy and not finishing: overflow (see Configuration).
- Arithmetic: counters $clog2(B) bits; data passed unmodified, no arithmetic on lanes.

## Timing
- Reset: in_cnt, out_cnt 0; hold_valid, obuf_valid, out_overflow 0; core_in_valid, out_valid 0; in_ready 0 while rst high; all data registers 0.
- rst mid-frame discards partial assembly, hold vector and output buffer; in_ready 1 the cycle after rst deasserts.
- Input latency: last beat accepted in cycle t → core_in_valid high in t+1.
- Output latency: core_out_valid in cycle t → out_valid with beat 0 in t+1; with out_ready held high, B consecutive beats.
- Sustained throughput: one beat per cycle each side when core_in_ready/out_ready held high.

## Configuration
- NTT_IO_GEARBOX_OVF_DROP_EN defined: overflowing core vector is dropped, buffer content and out_cnt preserved, out_overflow set and sticky until rst.
- Undefined: overflowing core vector overwrites buffer, out_cnt resets to 0 (partial frame truncated); out_overflow tied 0.

## Test plan
- W=28,N=32,L=4: 8 beats lanes value=index (0..31), core_in_ready=1 -> core_in_valid one cycle after beat 7, core_in_data[i]=i.
- core_in_ready=0, stream 16 beats -> first vector held in hold register, in_ready low at in_cnt=7 until core_in_ready pulses; second vector intact, no beat lost.
- core_out_valid with core_out_data[i]=0x1000+i, out_ready=1 -> beats 0..7 on consecutive cycles, beat 7 lane 3 = 0x101F; second strobe in last-beat cycle -> next frame starts with no bubble.
- out_ready toggling 1/0 -> out_data stable while stalled, 8 beats in order.
- With NTT_IO_GEARBOX_OVF_DROP_EN: second core_out_valid at out_cnt=3 -> out_overflow=1, frame continues with original data; without it: out_cnt→0, new data output, out_overflow=0.
- rst asserted at in_cnt=5 -> after release, 8 fresh beats produce exactly one vector with only new data.
